// File: rtl/vga_timing_checker_if.sv
// ---------------------------------------------------------------------------
// vga_timing_checker_if
// Raster and status bundle between a VGA source and the timing checker.
//   hsync, vsync   active-low syncs from the source
//   blank_b        high during active video
//   clear_err      synchronous clear of the sticky error flags
//   x, y           recovered pixel coordinates (valid with pix_valid)
//   pix_valid      locked and inside the predicted active region
//   locked         checker is in its LOCKED state
//   lock_lost      one-cycle pulse when lock is dropped
//   line_len       last measured hsync period
//   frame_lines    last measured lines per frame
//   frame_cnt      frames counted while locked (wraps)
//   err_hlen, err_vlen, err_blank   sticky timing error flags
// master: the source / observer side.  slave: the checker.
// ---------------------------------------------------------------------------
interface vga_timing_checker_if;
   logic        hsync;
   logic        vsync;
   logic        blank_b;
   logic        clear_err;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        pix_valid;
   logic        locked;
   logic        lock_lost;
   logic [10:0] line_len;
   logic [9:0]  frame_lines;
   logic [15:0] frame_cnt;
   logic        err_hlen;
   logic        err_vlen;
   logic        err_blank;

   modport master (
      output hsync, vsync, blank_b, clear_err,
      input  x, y, pix_valid, locked, lock_lost, line_len, frame_lines,
             frame_cnt, err_hlen, err_vlen, err_blank
   );

   modport slave (
      input  hsync, vsync, blank_b, clear_err,
      output x, y, pix_valid, locked, lock_lost, line_len, frame_lines,
             frame_cnt, err_hlen, err_vlen, err_blank
   );
endinterface

// File: rtl/vga_timing_checker.sv
// ---------------------------------------------------------------------------
// vga_timing_checker
// Sink-side monitor for a VGA raster.  Recovers hpos/vpos from the sync
// falling edges, measures line and frame lengths, tracks lock and raises
// sticky errors for bad line length, bad frame length and blank_b that
// disagrees with the predicted active window.
// Ports:
//   vgaclk   pixel clock, all logic on its rising edge
//   reset_n  asynchronous active-low reset
//   vga      vga_timing_checker_if.slave (syncs/blank/clear in, status out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SEARCH   | no timing reference yet; wait for a vsync falling edge
// MEASURE  | one frame being measured; any error goes back to SEARCH
// LOCKED   | timing confirmed; frames counted, errors drop lock
// ---------------------------------------------------------------------------
module vga_timing_checker #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_ACT_START = 144,
   parameter int V_ACT_START = 34
) (
   input  logic                 vgaclk,
   input  logic                 reset_n,
   vga_timing_checker_if.slave  vga
);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t      state_q, state_d;

   logic        hs_q, vs_q;
   logic        hs_fall, vs_fall;
   logic [10:0] hpos_q, hpos_d;
   logic [9:0]  vpos_q, vpos_d;
   logic        hs_seen_q, hs_seen_d;

   logic [11:0] line_meas;
   logic [10:0] frame_meas;
   logic        timeout;
   logic        line_err, frame_err;
   logic        active;

   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        pix_valid_q, pix_valid_d;
   logic        lock_lost_q, lock_lost_d;
   logic [10:0] line_len_q, line_len_d;
   logic [9:0]  frame_lines_q, frame_lines_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        err_hlen_q, err_hlen_d;
   logic        err_vlen_q, err_vlen_d;
   logic        err_blank_q, err_blank_d;

   // Raster position and measurement decode.  hpos_d/vpos_d are the
   // coordinates of the sample being taken this cycle.
   always_comb begin
      hs_fall = hs_q & ~vga.hsync;
      vs_fall = vs_q & ~vga.vsync;

      hpos_d = hpos_q;
      if (hs_fall) begin
         hpos_d = 11'd0;
      end else if (hpos_q != 11'h7FF) begin
         hpos_d = hpos_q + 11'd1;
      end

      vpos_d = vpos_q;
      if (vs_fall) begin
         vpos_d = 10'd0;
      end else if (hs_fall && (vpos_q != 10'h3FF)) begin
         vpos_d = vpos_q + 10'd1;
      end

      // Measured in one extra bit so a saturated counter never aliases
      // onto the expected total.
      line_meas  = {1'b0, hpos_q} + 12'd1;
      frame_meas = {1'b0, vpos_q} + {10'd0, hs_fall};

      // hpos is about to reach its ceiling: the line never ended.
      timeout   = ~hs_fall & (hpos_q == 11'd2046);
      line_err  = timeout |
                  (hs_fall & hs_seen_q & (line_meas != 12'(H_TOTAL)));
      frame_err = vs_fall & (frame_meas != 11'(V_TOTAL));

      active = (hpos_d >= 11'(H_ACT_START)) &&
               (hpos_d <  11'(H_ACT_START + H_ACTIVE)) &&
               (vpos_d >= 10'(V_ACT_START)) &&
               (vpos_d <  10'(V_ACT_START + V_ACTIVE));

      // A line is only trusted once it started after SEARCH was left.
      if (state_q == ST_SEARCH) begin
         hs_seen_d = 1'b0;
      end else begin
         hs_seen_d = hs_seen_q | hs_fall;
      end
   end

   // State register
   always_ff @(posedge vgaclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEARCH: begin
            if (vs_fall) begin
               state_d = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (line_err) begin
               state_d = ST_SEARCH;
            end else if (vs_fall) begin
               state_d = frame_err ? ST_SEARCH : ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (line_err || frame_err) begin
               state_d = ST_SEARCH;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   // Output logic (next values of the registered outputs)
   always_comb begin
      lock_lost_d = (state_q == ST_LOCKED) & (line_err | frame_err);

      frame_cnt_d = frame_cnt_q;
      if ((state_q == ST_LOCKED) && vs_fall && !line_err && !frame_err) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end

      line_len_d    = hs_fall ? line_meas[10:0] : line_len_q;
      frame_lines_d = vs_fall ? frame_meas[9:0] : frame_lines_q;

      // Set has priority over clear so no event is lost.
      err_hlen_d = err_hlen_q;
      if ((state_q != ST_SEARCH) && line_err) begin
         err_hlen_d = 1'b1;
      end else if (vga.clear_err) begin
         err_hlen_d = 1'b0;
      end

      err_vlen_d = err_vlen_q;
      if ((state_q != ST_SEARCH) && frame_err) begin
         err_vlen_d = 1'b1;
      end else if (vga.clear_err) begin
         err_vlen_d = 1'b0;
      end

      err_blank_d = err_blank_q;
      if ((state_q == ST_LOCKED) && (vga.blank_b != active)) begin
         err_blank_d = 1'b1;
      end else if (vga.clear_err) begin
         err_blank_d = 1'b0;
      end

      pix_valid_d = (state_q == ST_LOCKED) & active;

      // hpos_d is below 1024 whenever pix_valid_d is set.
      x_d = x_q;
      y_d = y_q;
      if (pix_valid_d) begin
         x_d = hpos_d[9:0] - 10'(H_ACT_START);
         y_d = vpos_d - 10'(V_ACT_START);
      end
   end

   // Datapath and output registers
   always_ff @(posedge vgaclk or negedge reset_n) begin
      if (!reset_n) begin
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         hpos_q        <= 11'd0;
         vpos_q        <= 10'd0;
         hs_seen_q     <= 1'b0;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         pix_valid_q   <= 1'b0;
         lock_lost_q   <= 1'b0;
         line_len_q    <= 11'd0;
         frame_lines_q <= 10'd0;
         frame_cnt_q   <= 16'd0;
         err_hlen_q    <= 1'b0;
         err_vlen_q    <= 1'b0;
         err_blank_q   <= 1'b0;
      end else begin
         hs_q          <= vga.hsync;
         vs_q          <= vga.vsync;
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         hs_seen_q     <= hs_seen_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_valid_q   <= pix_valid_d;
         lock_lost_q   <= lock_lost_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         frame_cnt_q   <= frame_cnt_d;
         err_hlen_q    <= err_hlen_d;
         err_vlen_q    <= err_vlen_d;
         err_blank_q   <= err_blank_d;
      end
   end

   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.pix_valid   = pix_valid_q;
   assign vga.locked      = (state_q == ST_LOCKED);
   assign vga.lock_lost   = lock_lost_q;
   assign vga.line_len    = line_len_q;
   assign vga.frame_lines = frame_lines_q;
   assign vga.frame_cnt   = frame_cnt_q;
   assign vga.err_hlen    = err_hlen_q;
   assign vga.err_vlen    = err_vlen_q;
   assign vga.err_blank   = err_blank_q;

endmodule
